// File: rtl/layer_scheduler.sv
// Layer scheduler: sequences load, compute, drain and write-back of CNN layer
// tiles for CONVOL, FULLY and POOL layers.
module layer_scheduler #(
    parameter int unsigned PE_ARRAY_SIZE = 9,
    parameter int unsigned POOL_SIZE     = 4,
    parameter int unsigned DRAIN_CYC     = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] num_tiles,
    output logic             buf_load_req,
    input  logic             buf_load_done,
    output logic             pe_clr,
    output logic             pe_en,
    output logic             pool_en,
    output logic             relu_en,
    output logic             ofm_valid,
    input  logic             ofm_ready,
    output logic [CNT_W-1:0] tile_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] MODE_ILLEGAL = 2'b00;
    localparam logic [1:0] MODE_POOL    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] tile_q;
    logic [CNT_W-1:0] cyc_cnt;
    logic             err_q;

    logic             is_pool;
    logic             compute_last;
    logic             drain_last;
    logic             tile_last;
    logic             start_ok;
    logic             start_bad;

    assign is_pool      = (mode_q == MODE_POOL);
    assign compute_last = (cyc_cnt == (is_pool ? CNT_W'(POOL_SIZE - 1)
                                               : CNT_W'(PE_ARRAY_SIZE - 1)));
    assign drain_last   = (cyc_cnt == CNT_W'(DRAIN_CYC - 1));
    assign tile_last    = (tile_q == (num_q - CNT_W'(1)));
    assign start_ok     = (state == S_IDLE) && start && (mode != MODE_ILLEGAL);
    assign start_bad    = (state == S_IDLE) && start && (mode == MODE_ILLEGAL);

    assign tile_idx = tile_q;
    assign err      = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = (num_tiles == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (buf_load_done) begin
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (compute_last) begin
                    state_next = (DRAIN_CYC == 0) ? S_WRITE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ofm_ready) begin
                    state_next = tile_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from state and counters
    always_comb begin
        buf_load_req = 1'b0;
        pe_clr       = 1'b0;
        pe_en        = 1'b0;
        pool_en      = 1'b0;
        relu_en      = 1'b0;
        ofm_valid    = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        case (state)
            S_LOAD: begin
                buf_load_req = 1'b1;
            end
            S_COMPUTE: begin
                pe_clr  = !is_pool && (cyc_cnt == '0);
                pe_en   = !is_pool;
                pool_en = is_pool;
            end
            S_DRAIN: begin
                relu_en = !is_pool;
            end
            S_WRITE: begin
                ofm_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Layer parameters, tile index, phase cycle counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            num_q   <= '0;
            tile_q  <= '0;
            cyc_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            // Restart the phase counter whenever the state changes
            cyc_cnt <= (state_next != state) ? '0 : cyc_cnt + CNT_W'(1);
            if (start_ok) begin
                mode_q <= mode;
                num_q  <= num_tiles;
                tile_q <= '0;
                err_q  <= 1'b0;
            end else if (start_bad) begin
                err_q <= 1'b1;
            end
            if ((state == S_WRITE) && ofm_ready && !tile_last) begin
                tile_q <= tile_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: each layer run is expanded from the tile rules
// into an expected per-cycle output trace and compared cycle by cycle.
module tb_layer_scheduler;

    localparam int unsigned N_PE    = 9;
    localparam int unsigned N_POOL  = 4;
    localparam int unsigned N_DRAIN = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] num_tiles;
    logic        buf_load_req;
    logic        buf_load_done;
    logic        pe_clr;
    logic        pe_en;
    logic        pool_en;
    logic        relu_en;
    logic        ofm_valid;
    logic        ofm_ready;
    logic [15:0] tile_idx;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int cyc;

    // Model-side view of what IDLE should show
    logic        cur_err;
    logic [15:0] cur_idx;

    layer_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .num_tiles    (num_tiles),
        .buf_load_req (buf_load_req),
        .buf_load_done(buf_load_done),
        .pe_clr       (pe_clr),
        .pe_en        (pe_en),
        .pool_en      (pool_en),
        .relu_en      (relu_en),
        .ofm_valid    (ofm_valid),
        .ofm_ready    (ofm_ready),
        .tile_idx     (tile_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack expected outputs: busy,req,clr,pe,pool,relu,ofm_valid,done,err,tile_idx
    function automatic logic [24:0] ev(input logic b, input logic rq, input logic cl,
                                       input logic pe, input logic pl, input logic rl,
                                       input logic ov, input logic dn, input logic er,
                                       input logic [15:0] idx);
        return {b, rq, cl, pe, pl, rl, ov, dn, er, idx};
    endfunction

    // Check this cycle's outputs, then drive this cycle's inputs and advance
    task automatic step(input string tag, input logic [24:0] exp_v, input logic st,
                        input logic [1:0] md, input logic [15:0] nt, input logic ld,
                        input logic ordy, input logic r);
        logic [24:0] obs;
        obs = {busy, buf_load_req, pe_clr, pe_en, pool_en, relu_en, ofm_valid, done, err,
               tile_idx};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp_v);
        end
        start         = st;
        mode          = md;
        num_tiles     = nt;
        buf_load_done = ld;
        ofm_ready     = ordy;
        rst           = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic rb(input logic en);
        return en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Idle cycles; optional stray handshakes which must be ignored
    task automatic idle(input int n, input logic noise);
        for (int i = 0; i < n; i++) begin
            step("idle", ev(0, 0, 0, 0, 0, 0, 0, 0, cur_err, cur_idx), 1'b0, 2'b00, 16'd0,
                 rb(noise), rb(noise), 1'b0);
        end
    endtask

    // One layer from start request to DONE, expanded from the tile rules
    task automatic run_layer(input logic [1:0] md, input logic [15:0] n, input int ld_dly,
                             input int wr_dly, input logic noise);
        logic pool;
        int   ncomp;
        pool  = (md == 2'b11);
        ncomp = pool ? int'(N_POOL) : int'(N_PE);
        step("start", ev(0, 0, 0, 0, 0, 0, 0, 0, cur_err, cur_idx), 1'b1, md, n, 1'b0,
             1'b0, 1'b0);
        if (md == 2'b00) begin
            cur_err = 1'b1;
            step("illegal", ev(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, cur_idx), 1'b0, 2'b00, 16'd0,
                 1'b0, 1'b0, 1'b0);
            return;
        end
        cur_err = 1'b0;
        cur_idx = 16'd0;
        for (int t = 0; t < int'(n); t++) begin
            for (int c = 0; c <= ld_dly; c++) begin
                step("load", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'(t)), rb(noise),
                     2'($urandom_range(0, 3)), 16'($urandom_range(0, 7)), 1'(c == ld_dly),
                     rb(noise), 1'b0);
            end
            for (int c = 0; c < ncomp; c++) begin
                step("compute", ev(1, 0, !pool && (c == 0), !pool, pool, 0, 0, 0, 0,
                                   16'(t)), rb(noise), 2'($urandom_range(0, 3)),
                     16'($urandom_range(0, 7)), rb(noise), rb(noise), 1'b0);
            end
            for (int c = 0; c < int'(N_DRAIN); c++) begin
                step("drain", ev(1, 0, 0, 0, 0, !pool, 0, 0, 0, 16'(t)), rb(noise),
                     2'($urandom_range(0, 3)), 16'($urandom_range(0, 7)), rb(noise),
                     rb(noise), 1'b0);
            end
            for (int c = 0; c <= wr_dly; c++) begin
                step("write", ev(1, 0, 0, 0, 0, 0, 1, 0, 0, 16'(t)), rb(noise),
                     2'($urandom_range(0, 3)), 16'($urandom_range(0, 7)), rb(noise),
                     1'(c == wr_dly), 1'b0);
            end
            cur_idx = 16'(t);
        end
        step("done", ev(1, 0, 0, 0, 0, 0, 0, 1, 0, cur_idx), rb(noise),
             2'($urandom_range(0, 3)), 16'($urandom_range(0, 7)), rb(noise), rb(noise), 1'b0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        cur_err       = 1'b0;
        cur_idx       = 16'd0;
        rst           = 1'b1;
        start         = 1'b0;
        mode          = 2'b00;
        num_tiles     = 16'd0;
        buf_load_done = 1'b0;
        ofm_ready     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        step("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0), 1'b0, 2'b00, 16'd0, 1'b0, 1'b0,
             1'b0);

        // CONVOL, two tiles, zero-wait handshakes
        run_layer(2'b01, 16'd2, 0, 0, 1'b0);
        idle(2, 1'b0);
        // POOL, one tile
        run_layer(2'b11, 16'd1, 0, 0, 1'b0);
        idle(1, 1'b0);
        // FULLY with slow load ack and slow OFM buffer
        run_layer(2'b10, 16'd1, 5, 3, 1'b0);
        idle(1, 1'b1);
        // Illegal mode sets err; the next legal start clears it
        run_layer(2'b00, 16'd3, 0, 0, 1'b0);
        idle(2, 1'b1);
        run_layer(2'b01, 16'd1, 0, 0, 1'b0);
        idle(1, 1'b0);
        // Zero tiles: straight to DONE
        run_layer(2'b01, 16'd0, 0, 0, 1'b0);
        idle(2, 1'b0);

        // Randomized layers with stray handshakes and ignored start requests
        for (int k = 0; k < 10; k++) begin
            run_layer(2'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1);
            idle(int'($urandom_range(1, 3)), 1'b1);
        end

        // Reset during the 4th COMPUTE cycle, with start also high
        step("rstseq", ev(0, 0, 0, 0, 0, 0, 0, 0, cur_err, cur_idx), 1'b1, 2'b01, 16'd2,
             1'b0, 1'b0, 1'b0);
        step("rstseq", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'd0), 1'b0, 2'b00, 16'd0, 1'b1, 1'b0,
             1'b0);
        for (int c = 0; c < 3; c++) begin
            step("rstseq", ev(1, 0, 1'(c == 0), 1, 0, 0, 0, 0, 0, 16'd0), 1'b0, 2'b00,
                 16'd0, 1'b0, 1'b0, 1'b0);
        end
        step("rstseq", ev(1, 0, 0, 1, 0, 0, 0, 0, 0, 16'd0), 1'b1, 2'b01, 16'd2, 1'b1, 1'b1,
             1'b1);
        cur_err = 1'b0;
        cur_idx = 16'd0;
        step("rst_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0), 1'b0, 2'b00, 16'd0, 1'b0,
             1'b0, 1'b0);
        idle(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
